// File: rtl/sp_types_pkg.sv
// rtl/sp_types_pkg.sv - shared types and constants for the matrix load/store sequencer
package sp_types_pkg;

  localparam int MAT_ROWS  = 4;
  localparam int ROW_W     = 64;
  localparam int ADDR_W    = 32;
  localparam int MATREG_W  = 4;
  localparam int ROW_IDX_W = $clog2(MAT_ROWS);

  typedef enum logic [1:0] {
    MM_NONE  = 2'd0,
    MM_LOAD  = 2'd1,
    MM_STORE = 2'd2,
    MM_RSVD  = 2'd3
  } matrix_mem_t;

  typedef logic [ROW_W-1:0]     matbits_t;
  typedef logic [ROW_IDX_W-1:0] row_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_REQ,
    S_LD_WAIT,
    S_ST_RD,
    S_ST_REQ,
    S_DONE
  } sp_ls_state_t;

endpackage

// File: rtl/sp_matls_sequencer_if.sv
// rtl/sp_matls_sequencer_if.sv - row-granular memory request/response bus
interface sp_matls_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int ROW_W  = 64
);
  logic              mem_req;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [ROW_W-1:0]  mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [ROW_W-1:0]  mem_rdata;

  // sequencer side issues requests
  modport master (
    output mem_req, mem_wen, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  // memory side accepts requests and returns read data
  modport slave (
    input  mem_req, mem_wen, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/sp_row_addr_gen.sv
// rtl/sp_row_addr_gen.sv - latched base address plus row counter to per-row byte address
module sp_row_addr_gen #(
  parameter  int ADDR_W    = 32,
  parameter  int ROW_W     = 64,
  parameter  int MAT_ROWS  = 4,
  localparam int ROW_IDX_W = $clog2(MAT_ROWS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clear,
  input  logic                 inc,
  input  logic [ADDR_W-1:0]    base_in,
  output logic [ROW_IDX_W-1:0] row,
  output logic [ADDR_W-1:0]    row_addr,
  output logic                 last
);

  logic [ADDR_W-1:0] base;

  // clear latches a new base and restarts at row 0; inc steps to the next row
  always_ff @(posedge CLK) begin
    if (RST) begin
      base <= '0;
      row  <= '0;
    end else if (clear) begin
      base <= base_in;
      row  <= '0;
    end else if (inc) begin
      row <= row + 1'b1;
    end
  end

  // rows are contiguous in memory; the sum wraps silently at 2^ADDR_W
  always_comb begin
    row_addr = base + (ADDR_W'(row) * ADDR_W'(ROW_W / 8));
    last     = (row == ROW_IDX_W'(MAT_ROWS - 1));
  end

endmodule

// File: rtl/sp_matls_sequencer.sv
// rtl/sp_matls_sequencer.sv - moves whole matrices between memory and scratchpad, one row at a time
module sp_matls_sequencer #(
  parameter  int ADDR_W    = sp_types_pkg::ADDR_W,
  parameter  int ROW_W     = sp_types_pkg::ROW_W,
  parameter  int MAT_ROWS  = sp_types_pkg::MAT_ROWS,
  parameter  int MATREG_W  = sp_types_pkg::MATREG_W,
  localparam int ROW_IDX_W = $clog2(MAT_ROWS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 instr_valid,
  input  logic [1:0]           instr_ls,
  input  logic [MATREG_W-1:0]  instr_rd,
  input  logic [ADDR_W-1:0]    instr_addr,
  output logic                 instr_pop,
  sp_matls_sequencer_if.master mem,
  output logic                 sp_wen,
  output logic                 sp_ren,
  output logic [MATREG_W-1:0]  sp_mat,
  output logic [ROW_IDX_W-1:0] sp_row,
  output logic [ROW_W-1:0]     sp_wdata,
  input  logic [ROW_W-1:0]     sp_rdata,
  output logic                 done,
  output logic [MATREG_W-1:0]  done_rd,
  output logic                 done_ls,
  output logic                 busy
);

  import sp_types_pkg::*;

  sp_ls_state_t          state, next_state;
  matrix_mem_t           ls_q;
  logic [MATREG_W-1:0]   rd_q;
  logic [ROW_W-1:0]      st_data;
  logic                  st_first;
  logic                  accept;
  logic                  row_inc;
  logic                  row_last;
  logic [ROW_IDX_W-1:0]  row;
  logic [ADDR_W-1:0]     row_addr;

  // an entry is taken only from IDLE, and never while reset is held
  assign accept = (state == S_IDLE) && instr_valid && !RST;

  // the counter never wraps: the last row exits to DONE instead of incrementing
  assign row_inc = ((state == S_LD_WAIT) && mem.mem_rvalid && !row_last) ||
                   ((state == S_ST_REQ)  && mem.mem_gnt    && !row_last);

  assign busy = (state != S_IDLE);

  sp_row_addr_gen #(
    .ADDR_W   (ADDR_W),
    .ROW_W    (ROW_W),
    .MAT_ROWS (MAT_ROWS)
  ) u_addr_gen (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (accept),
    .inc      (row_inc),
    .base_in  (instr_addr),
    .row      (row),
    .row_addr (row_addr),
    .last     (row_last)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  // next-state: one row per LD_REQ/LD_WAIT or ST_RD/ST_REQ pair
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          case (matrix_mem_t'(instr_ls))
            MM_LOAD:  next_state = S_LD_REQ;
            MM_STORE: next_state = S_ST_RD;
            default:  next_state = S_IDLE;
          endcase
        end
      end
      S_LD_REQ:  if (mem.mem_gnt)    next_state = S_LD_WAIT;
      S_LD_WAIT: if (mem.mem_rvalid) next_state = row_last ? S_DONE : S_LD_REQ;
      S_ST_RD:   next_state = S_ST_REQ;
      S_ST_REQ:  if (mem.mem_gnt)    next_state = row_last ? S_DONE : S_ST_RD;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // latched instruction fields and the store-data holding register
  always_ff @(posedge CLK) begin
    if (RST) begin
      ls_q     <= MM_NONE;
      rd_q     <= '0;
      st_first <= 1'b0;
      st_data  <= '0;
    end else begin
      if (accept) begin
        ls_q <= matrix_mem_t'(instr_ls);
        rd_q <= instr_rd;
      end
      st_first <= (state == S_ST_RD);
      if (st_first) st_data <= sp_rdata;
    end
  end

  // outputs decoded from state; on the first ST_REQ cycle the scratchpad read
  // data is forwarded directly so an immediate grant still carries the row
  always_comb begin
    instr_pop     = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_wen   = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    sp_wen        = 1'b0;
    sp_ren        = 1'b0;
    sp_mat        = '0;
    sp_row        = '0;
    sp_wdata      = '0;
    case (state)
      S_IDLE: instr_pop = accept;
      S_LD_REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = row_addr;
      end
      S_LD_WAIT: begin
        if (mem.mem_rvalid) begin
          sp_wen   = 1'b1;
          sp_mat   = rd_q;
          sp_row   = row;
          sp_wdata = mem.mem_rdata;
        end
      end
      S_ST_RD: begin
        sp_ren = 1'b1;
        sp_mat = rd_q;
        sp_row = row;
      end
      S_ST_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_wen   = 1'b1;
        mem.mem_addr  = row_addr;
        mem.mem_wdata = st_first ? sp_rdata : st_data;
      end
      default: ;
    endcase
  end

  // completion pulse registered so it lines up with the DONE state
  always_ff @(posedge CLK) begin
    if (RST) begin
      done    <= 1'b0;
      done_rd <= '0;
      done_ls <= 1'b0;
    end else begin
      done    <= (next_state == S_DONE);
      done_rd <= (next_state == S_DONE) ? rd_q : '0;
      done_ls <= (next_state == S_DONE) && (ls_q == MM_STORE);
    end
  end

endmodule

// File: tb/tb_sp_matls_sequencer.sv
// tb/tb_sp_matls_sequencer.sv - directed self-checking bench for sp_matls_sequencer
module tb_sp_matls_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        instr_valid;
  logic [1:0]  instr_ls;
  logic [3:0]  instr_rd;
  logic [31:0] instr_addr;
  logic        instr_pop;
  logic        sp_wen, sp_ren;
  logic [3:0]  sp_mat;
  logic [1:0]  sp_row;
  logic [63:0] sp_wdata, sp_rdata;
  logic        done;
  logic [3:0]  done_rd;
  logic        done_ls;
  logic        busy;

  always #5 CLK = ~CLK;

  sp_matls_sequencer_if #(.ADDR_W(32), .ROW_W(64)) mem_bus ();

  sp_matls_sequencer dut (
    .CLK(CLK), .RST(RST),
    .instr_valid(instr_valid), .instr_ls(instr_ls), .instr_rd(instr_rd), .instr_addr(instr_addr),
    .instr_pop(instr_pop), .mem(mem_bus),
    .sp_wen(sp_wen), .sp_ren(sp_ren), .sp_mat(sp_mat), .sp_row(sp_row),
    .sp_wdata(sp_wdata), .sp_rdata(sp_rdata),
    .done(done), .done_rd(done_rd), .done_ls(done_ls), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO model and logs
  logic [1:0]  f_ls[$];
  logic [3:0]  f_rd[$];
  logic [31:0] f_addr[$];
  int          pop_cyc[$], done_cyc[$];
  logic [3:0]  d_rd[$];
  logic        d_ls[$];
  logic [31:0] req_addr[$];
  logic [63:0] req_wdata[$];
  logic        req_wen[$], req_gnt[$];
  logic [3:0]  wr_mat[$];
  logic [1:0]  wr_row[$];
  logic [63:0] wr_data[$];
  int          stall_tbl[$];
  int          cyc, req_idx, stall_cnt, read_row, rst_req_idx, pop_busy;
  bit          spurious, rv_pending, rst_pending, post_rst_check, post_rst_seen;
  logic [63:0] rv_data;
  bit          spr_pending;
  logic [1:0]  spr_row;
  logic        post_rst_or;

  task automatic clear_logs();
    f_ls.delete(); f_rd.delete(); f_addr.delete();
    pop_cyc.delete(); done_cyc.delete(); d_rd.delete(); d_ls.delete();
    req_addr.delete(); req_wdata.delete(); req_wen.delete(); req_gnt.delete();
    wr_mat.delete(); wr_row.delete(); wr_data.delete(); stall_tbl.delete();
    req_idx = 0; stall_cnt = 0; read_row = 0; rst_req_idx = -1; pop_busy = 0;
    spurious = 0; rv_pending = 0; rst_pending = 0; post_rst_check = 0; post_rst_seen = 0;
    spr_pending = 0; post_rst_or = 1'b1;
  endtask

  task automatic push(input logic [1:0] ls, input logic [3:0] rd, input logic [31:0] addr);
    f_ls.push_back(ls); f_rd.push_back(rd); f_addr.push_back(addr);
  endtask

  // cycle-level environment: inputs change at negedge, outputs sampled 1 time unit later
  task automatic run(input int max_cyc, output bit timed_out);
    int used;
    int idle_cnt;
    int need;
    used = 0; idle_cnt = 0; timed_out = 0;
    while (idle_cnt < 2) begin
      if (used >= max_cyc) begin
        timed_out = 1;
        break;
      end
      @(negedge CLK);
      cyc++; used++;
      RST = 1'b0;
      instr_valid = (f_ls.size() > 0);
      instr_ls    = (f_ls.size() > 0) ? f_ls[0]   : 2'd0;
      instr_rd    = (f_ls.size() > 0) ? f_rd[0]   : 4'd0;
      instr_addr  = (f_ls.size() > 0) ? f_addr[0] : 32'd0;
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
      if (rst_pending) begin
        RST = 1'b1; rst_pending = 0; post_rst_check = 1;
      end else if (rv_pending) begin
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = rv_data; rv_pending = 0;
      end
      sp_rdata = spr_pending ? (64'hA0 + 64'(spr_row)) : 64'h0;
      spr_pending = 0;
      if (mem_bus.mem_req) begin
        need = (req_idx < stall_tbl.size()) ? stall_tbl[req_idx] : 0;
        if (stall_cnt < need) begin
          stall_cnt++;
          if (spurious && !mem_bus.mem_wen && !mem_bus.mem_rvalid) begin
            mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 64'hDEAD;
          end
        end else begin
          mem_bus.mem_gnt = 1'b1;
        end
      end
      #1;
      if (post_rst_check && !RST) begin
        post_rst_seen = 1; post_rst_check = 0;
        post_rst_or = |{instr_pop, mem_bus.mem_req, mem_bus.mem_wen, mem_bus.mem_addr,
                        mem_bus.mem_wdata, sp_wen, sp_ren, sp_mat, sp_row, sp_wdata,
                        done, done_rd, done_ls, busy};
      end
      if (instr_pop) begin
        if (busy) pop_busy++;
        pop_cyc.push_back(cyc);
        if (f_ls.size() > 0) begin
          void'(f_ls.pop_front()); void'(f_rd.pop_front()); void'(f_addr.pop_front());
        end
        read_row = 0;
      end
      if (mem_bus.mem_req) begin
        req_addr.push_back(mem_bus.mem_addr); req_wdata.push_back(mem_bus.mem_wdata);
        req_wen.push_back(mem_bus.mem_wen);   req_gnt.push_back(mem_bus.mem_gnt);
        if (mem_bus.mem_gnt) begin
          if (!mem_bus.mem_wen) begin
            if (req_idx == rst_req_idx) rst_pending = 1;
            else begin rv_pending = 1; rv_data = 64'(read_row); end
            read_row++;
          end
          req_idx++; stall_cnt = 0;
        end
      end
      if (sp_ren) begin spr_pending = 1; spr_row = sp_row; end
      if (sp_wen) begin wr_mat.push_back(sp_mat); wr_row.push_back(sp_row); wr_data.push_back(sp_wdata); end
      if (done) begin done_cyc.push_back(cyc); d_rd.push_back(done_rd); d_ls.push_back(done_ls); end
      if (!busy && f_ls.size() == 0 && !rv_pending && !rst_pending && !RST) idle_cnt++;
      else idle_cnt = 0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; instr_valid = 1'b1; instr_ls = 2'd1; instr_rd = 4'd3; instr_addr = 32'h1234;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0; sp_rdata = '0;
    repeat (3) @(negedge CLK);
    #1;
    n_cmp++; if (instr_pop !== 1'b0) begin n_bad++; $display("FAIL reset_pop: got %0b want 0", instr_pop); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (mem_bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %0h want 0", mem_bus.mem_addr); end
    n_cmp++; if (done_rd !== 4'h0) begin n_bad++; $display("FAIL reset_done_rd: got %0h want 0", done_rd); end
    n_cmp++;
    if ((|{mem_bus.mem_req, mem_bus.mem_wen, mem_bus.mem_wdata, sp_wen, sp_ren, sp_mat, sp_row, sp_wdata, done, done_ls}) !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: got nonzero want 0");
    end
    instr_valid = 1'b0;
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_load();
    bit to;
    clear_logs(); push(2'd1, 4'd3, 32'h1000); run(60, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL load_timeout: got timeout want completion"); end
    n_cmp++; if (done_cyc.size() !== 1) begin n_bad++; $display("FAIL load_done_cnt: got %0d want 1", done_cyc.size()); end
    n_cmp++; if (req_addr.size() !== 4) begin n_bad++; $display("FAIL load_req_cnt: got %0d want 4", req_addr.size()); end
    n_cmp++; if (wr_data.size() !== 4) begin n_bad++; $display("FAIL load_wr_cnt: got %0d want 4", wr_data.size()); end
    if (done_cyc.size() == 1 && pop_cyc.size() == 1) begin
      n_cmp++; if (done_cyc[0] - pop_cyc[0] !== 9) begin n_bad++; $display("FAIL load_latency: got %0d want 9", done_cyc[0] - pop_cyc[0]); end
      n_cmp++; if (d_rd[0] !== 4'd3) begin n_bad++; $display("FAIL load_done_rd: got %0d want 3", d_rd[0]); end
      n_cmp++; if (d_ls[0] !== 1'b0) begin n_bad++; $display("FAIL load_done_ls: got %0b want 0", d_ls[0]); end
    end
    for (int i = 0; i < 4 && i < req_addr.size(); i++) begin
      n_cmp++; if (req_addr[i] !== 32'h1000 + 32'(8 * i) || req_wen[i] !== 1'b0) begin
        n_bad++; $display("FAIL load_addr[%0d]: got %0h wen %0b want %0h wen 0", i, req_addr[i], req_wen[i], 32'h1000 + 32'(8 * i));
      end
    end
    for (int i = 0; i < 4 && i < wr_data.size(); i++) begin
      n_cmp++; if (wr_mat[i] !== 4'd3 || wr_row[i] !== 2'(i) || wr_data[i] !== 64'(i)) begin
        n_bad++; $display("FAIL load_sp_write[%0d]: got mat %0d row %0d data %0h want mat 3 row %0d data %0h", i, wr_mat[i], wr_row[i], wr_data[i], i, i);
      end
    end
  endtask

  task automatic test_store_stall();
    bit to;
    logic [31:0] ea[7] = '{32'h2000, 32'h2008, 32'h2008, 32'h2008, 32'h2008, 32'h2010, 32'h2018};
    logic [63:0] ed[7] = '{64'hA0, 64'hA1, 64'hA1, 64'hA1, 64'hA1, 64'hA2, 64'hA3};
    logic        eg[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    clear_logs(); stall_tbl.push_back(0); stall_tbl.push_back(3);
    push(2'd2, 4'd5, 32'h2000); run(60, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL store_timeout: got timeout want completion"); end
    n_cmp++; if (req_addr.size() !== 7) begin n_bad++; $display("FAIL store_req_cnt: got %0d want 7", req_addr.size()); end
    for (int i = 0; i < 7 && i < req_addr.size(); i++) begin
      n_cmp++; if (req_addr[i] !== ea[i] || req_wdata[i] !== ed[i] || req_gnt[i] !== eg[i] || req_wen[i] !== 1'b1) begin
        n_bad++; $display("FAIL store_req[%0d]: got addr %0h data %0h gnt %0b wen %0b want addr %0h data %0h gnt %0b wen 1", i, req_addr[i], req_wdata[i], req_gnt[i], req_wen[i], ea[i], ed[i], eg[i]);
      end
    end
    n_cmp++; if (done_cyc.size() !== 1) begin n_bad++; $display("FAIL store_done_cnt: got %0d want 1", done_cyc.size()); end
    if (done_cyc.size() == 1 && pop_cyc.size() == 1) begin
      n_cmp++; if (d_rd[0] !== 4'd5 || d_ls[0] !== 1'b1) begin n_bad++; $display("FAIL store_done_tag: got rd %0d ls %0b want rd 5 ls 1", d_rd[0], d_ls[0]); end
      n_cmp++; if (done_cyc[0] - pop_cyc[0] !== 12) begin n_bad++; $display("FAIL store_latency: got %0d want 12", done_cyc[0] - pop_cyc[0]); end
    end
    n_cmp++; if (wr_data.size() !== 0) begin n_bad++; $display("FAIL store_sp_wen: got %0d writes want 0", wr_data.size()); end
  endtask

  task automatic test_none_then_load();
    bit to;
    clear_logs(); push(2'd0, 4'd7, 32'h3000); push(2'd1, 4'd1, 32'h4000); run(60, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL none_timeout: got timeout want completion"); end
    n_cmp++; if (pop_cyc.size() !== 2) begin n_bad++; $display("FAIL none_pop_cnt: got %0d want 2", pop_cyc.size()); end
    n_cmp++; if (done_cyc.size() !== 1) begin n_bad++; $display("FAIL none_done_cnt: got %0d want 1", done_cyc.size()); end
    n_cmp++; if (req_addr.size() !== 4) begin n_bad++; $display("FAIL none_req_cnt: got %0d want 4", req_addr.size()); end
    if (pop_cyc.size() == 2 && done_cyc.size() == 1 && req_addr.size() > 0) begin
      n_cmp++; if (pop_cyc[1] - pop_cyc[0] !== 1) begin n_bad++; $display("FAIL none_pop_gap: got %0d want 1", pop_cyc[1] - pop_cyc[0]); end
      n_cmp++; if (d_rd[0] !== 4'd1) begin n_bad++; $display("FAIL none_done_rd: got %0d want 1", d_rd[0]); end
      n_cmp++; if (done_cyc[0] - pop_cyc[1] !== 9) begin n_bad++; $display("FAIL none_load_latency: got %0d want 9", done_cyc[0] - pop_cyc[1]); end
      n_cmp++; if (req_addr[0] !== 32'h4000) begin n_bad++; $display("FAIL none_first_addr: got %0h want 4000", req_addr[0]); end
    end
  endtask

  task automatic test_addr_wrap();
    bit to;
    logic [31:0] ea[4] = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008};
    clear_logs(); push(2'd1, 4'd9, 32'hFFFF_FFF0); run(60, to);
    n_cmp++; if (to || req_addr.size() !== 4) begin n_bad++; $display("FAIL wrap_req_cnt: got %0d timeout %0b want 4", req_addr.size(), to); end
    for (int i = 0; i < 4 && i < req_addr.size(); i++) begin
      n_cmp++; if (req_addr[i] !== ea[i]) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %0h want %0h", i, req_addr[i], ea[i]); end
    end
    n_cmp++; if (done_cyc.size() !== 1 || d_rd[0] !== 4'd9) begin n_bad++; $display("FAIL wrap_done: got %0d dones want 1 with rd 9", done_cyc.size()); end
  endtask

  task automatic test_spurious_and_reset();
    bit to;
    clear_logs(); stall_tbl.push_back(1); spurious = 1; rst_req_idx = 2;
    push(2'd1, 4'd6, 32'h6000); run(60, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL rst_timeout: got timeout want idle"); end
    n_cmp++; if (done_cyc.size() !== 0) begin n_bad++; $display("FAIL rst_no_done: got %0d dones want 0", done_cyc.size()); end
    n_cmp++; if (wr_data.size() !== 2) begin n_bad++; $display("FAIL rst_wr_cnt: got %0d want 2", wr_data.size()); end
    for (int i = 0; i < 2 && i < wr_data.size(); i++) begin
      n_cmp++; if (wr_data[i] !== 64'(i) || wr_row[i] !== 2'(i) || wr_mat[i] !== 4'd6) begin
        n_bad++; $display("FAIL rst_sp_write[%0d]: got mat %0d row %0d data %0h want mat 6 row %0d data %0h", i, wr_mat[i], wr_row[i], wr_data[i], i, i);
      end
    end
    n_cmp++; if (req_addr.size() !== 4) begin n_bad++; $display("FAIL rst_req_cnt: got %0d want 4", req_addr.size()); end
    if (req_addr.size() == 4) begin
      n_cmp++; if (req_addr[3] !== 32'h6010) begin n_bad++; $display("FAIL rst_last_addr: got %0h want 6010", req_addr[3]); end
    end
    n_cmp++; if (post_rst_seen !== 1'b1 || post_rst_or !== 1'b0) begin n_bad++; $display("FAIL rst_outputs_zero: got seen %0b nonzero %0b want seen 1 nonzero 0", post_rst_seen, post_rst_or); end
    clear_logs(); push(2'd1, 4'd2, 32'h5000); run(60, to);
    n_cmp++; if (to || done_cyc.size() !== 1 || pop_cyc.size() !== 1) begin n_bad++; $display("FAIL rst_next_done: got %0d dones want 1", done_cyc.size()); end
    else begin
      n_cmp++; if (d_rd[0] !== 4'd2 || done_cyc[0] - pop_cyc[0] !== 9) begin n_bad++; $display("FAIL rst_next_tag: got rd %0d latency %0d want rd 2 latency 9", d_rd[0], done_cyc[0] - pop_cyc[0]); end
      n_cmp++; if (req_addr[0] !== 32'h5000) begin n_bad++; $display("FAIL rst_next_addr: got %0h want 5000", req_addr[0]); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_logs(); push(2'd2, 4'd4, 32'h7000); push(2'd2, 4'd8, 32'h7100); run(80, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL b2b_timeout: got timeout want completion"); end
    n_cmp++; if (done_cyc.size() !== 2 || pop_cyc.size() !== 2) begin n_bad++; $display("FAIL b2b_counts: got %0d dones %0d pops want 2 2", done_cyc.size(), pop_cyc.size()); end
    else begin
      n_cmp++; if (pop_cyc[1] - done_cyc[0] !== 1) begin n_bad++; $display("FAIL b2b_bubble: got %0d want 1", pop_cyc[1] - done_cyc[0]); end
      n_cmp++; if (d_rd[0] !== 4'd4 || d_rd[1] !== 4'd8 || d_ls[0] !== 1'b1 || d_ls[1] !== 1'b1) begin
        n_bad++; $display("FAIL b2b_tags: got %0d/%0b %0d/%0b want 4/1 8/1", d_rd[0], d_ls[0], d_rd[1], d_ls[1]);
      end
    end
    n_cmp++; if (pop_busy !== 0) begin n_bad++; $display("FAIL b2b_pop_busy: got %0d want 0", pop_busy); end
    n_cmp++; if (req_addr.size() !== 8) begin n_bad++; $display("FAIL b2b_req_cnt: got %0d want 8", req_addr.size()); end
    else begin
      n_cmp++; if (req_addr[4] !== 32'h7100 || req_wdata[7] !== 64'hA3) begin
        n_bad++; $display("FAIL b2b_second: got addr %0h data %0h want 7100 a3", req_addr[4], req_wdata[7]);
      end
    end
  endtask

  initial begin
    cyc = 0;
    clear_logs();
    test_reset();
    test_load();
    test_store_stall();
    test_none_then_load();
    test_addr_wrap();
    test_spurious_and_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sp_matls_sequencer.md
Name: sp_matls_sequencer

Overview:
- Scratchpad-side consumer of the matrix load/store instruction FIFO; the other end of the FU's instruction output.
- Pops one instruction at a time: ls type, destination/source matrix register, effective address.
- Moves a whole matrix row by row:
  - LOAD: memory → scratchpad bank.
  - STORE: scratchpad bank → memory.
- Signals completion with the matrix register tag so the scoreboard can release it.

Parameters:
MAT_ROWS, 4, rows per matrix (power of 2)
ROW_W, 64, bits per row (4 x FP16)
ADDR_W, 32, byte address width
MATREG_W, 4, matrix register index width

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
instr_valid  input  1  instruction FIFO non-empty
instr_ls  input  2  matrix_mem_t: 0 NONE, 1 LOAD, 2 STORE
instr_rd  input  MATREG_W  matrix register
instr_addr  input  ADDR_W  base byte address
instr_pop  output  1  one-cycle FIFO pop
mem_req  output  1  memory request valid
mem_wen  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  row address
mem_wdata  output  ROW_W  store data
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  ROW_W  read data
sp_wen  output  1  scratchpad row write
sp_ren  output  1  scratchpad row read
sp_mat  output  MATREG_W  scratchpad matrix index
sp_row  output  clog2(MAT_ROWS)  row index
sp_wdata  output  ROW_W  scratchpad write data
sp_rdata  input  ROW_W  scratchpad read data, valid 1 cycle after sp_ren
done  output  1  one-cycle completion pulse
done_rd  output  MATREG_W  completed matrix register
done_ls  output  1  0 = load, 1 = store
busy  output  1  state != IDLE

Behaviour:
- Single clock CLK; reset RST is synchronous, active-high.
- Reset:
  - state = IDLE; row counter = 0.
  - All outputs 0, including done_rd and mem_addr.
  - Reset mid-operation abandons the instruction: no done, no further requests.
- FSM states: IDLE, LD_REQ, LD_WAIT, ST_RD, ST_REQ, DONE.
- IDLE:
  - If instr_valid: instr_pop = 1 (combinational, this cycle only); latch ls, rd, addr; row = 0.
  - Next state: LOAD → LD_REQ; STORE → ST_RD.
  - NONE or reserved (3): entry is discarded, stays IDLE, no done.
  - If not instr_valid: instr_pop = 0.
- Row address = base + row * (ROW_W/8), modulo 2^ADDR_W. The wrap is silent; no misalignment check.
- LD_REQ:
  - Outputs: mem_req = 1, mem_wen = 0, mem_addr = row address.
  - Held stable until mem_gnt. On mem_gnt → LD_WAIT.
- LD_WAIT:
  - mem_req = 0. Wait for mem_rvalid.
  - mem_rvalid outside LD_WAIT is ignored. Memory must not return data in the grant cycle.
  - On mem_rvalid (same cycle): sp_wen = 1, sp_mat = rd, sp_row = row, sp_wdata = mem_rdata.
  - Then last row → DONE; otherwise row++ → LD_REQ.
- ST_RD:
  - One cycle of sp_ren = 1, sp_mat = rd, sp_row = row → ST_REQ.
- ST_REQ:
  - On entry, register sp_rdata into the store-data register.
  - Outputs: mem_req = 1, mem_wen = 1, mem_addr = row address, mem_wdata = store-data register. Held until mem_gnt.
  - On mem_gnt: last row → DONE; otherwise row++ → ST_RD.
- DONE:
  - done = 1, done_rd = rd, done_ls = (ls == STORE) → IDLE.
  - No pop in DONE, so back-to-back instructions have a 1-cycle bubble.
- Only one memory request is outstanding at any time.
- Best-case latency, MAT_ROWS = 4, from pop to done:
  - Load (gnt immediate, rvalid next cycle): 1 + 4*2 = 9 cycles.
  - Store (gnt immediate): 1 + 4*2 = 9 cycles.
- A row counter wrap at the last row is never observed: the transition to DONE takes priority.
- busy is high in every state except IDLE.
- Registered outputs: done, done_rd, done_ls.
- Outputs decoded from state and latched fields: mem_*, sp_*, instr_pop.

Decomposition:
- Shared package sp_types_pkg:
  - matrix_mem_t encoding.
  - MAT_ROWS, ROW_W, MATREG_W constants; matbits_t; row_t.
  - sp_ls_state_t enum.
- Sub-module sp_row_addr_gen: holds the latched base and row counter; computes the row address; clear/increment/last outputs.

Test Plan:
- Load: FIFO {LOAD, rd = 3, addr = 0x1000}; gnt immediate, rvalid 1 cycle later with rdata = row index → mem_addr 0x1000/0x1008/0x1010/0x1018; sp_wen writes mat 3 rows 0-3 with 0..3; done with done_rd = 3, done_ls = 0 at cycle 9 after pop.
- Store: {STORE, rd = 5, addr = 0x2000}; scratchpad returns 0xA0+row; gnt delayed 3 cycles on row 1 → mem_addr/mem_wdata held stable while stalled; writes 0xA0..0xA3 to 0x2000..0x2018; single done, done_ls = 1.
- NONE then LOAD back-to-back → NONE popped with no memory traffic and no done; LOAD popped the next cycle and completes normally.
- Address wrap: LOAD at 0xFFFFFFF0 → row addresses 0xFFFFFFF0, 0xFFFFFFF8, 0x00000000, 0x00000008.
- Spurious mem_rvalid in LD_REQ ignored; RST asserted in LD_WAIT row 2 → next cycle all outputs 0, IDLE, no done, no sp_wen; next FIFO entry popped normally.
- Two queued STOREs → pops exactly 1 cycle after the first done; instr_pop never asserted while busy.
